// File: rtl/reset_sequencer_pkg.sv
// reset_sequencer_pkg: shared types and constants for the reset sequencer.
//   - state_e       : sequencer FSM states
//   - rst_out_t     : registered reset outputs (async, sync, done)
//   - OUT_*         : output decode per state
//   - decode_outputs: maps a state to its output vector
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2,
    SW_RST    = 2'd3
  } state_e;

  typedef struct packed {
    logic async_reset;
    logic sync_reset;
    logic rst_done;
  } rst_out_t;

  localparam rst_out_t OUT_WAIT_LOCK = '{async_reset: 1'b1, sync_reset: 1'b1, rst_done: 1'b0};
  localparam rst_out_t OUT_HOLD      = '{async_reset: 1'b1, sync_reset: 1'b1, rst_done: 1'b0};
  localparam rst_out_t OUT_RUN       = '{async_reset: 1'b0, sync_reset: 1'b0, rst_done: 1'b1};
  localparam rst_out_t OUT_SW_RST    = '{async_reset: 1'b0, sync_reset: 1'b1, rst_done: 1'b0};

  function automatic rst_out_t decode_outputs(input state_e s);
    rst_out_t o;
    case (s)
      WAIT_LOCK: o = OUT_WAIT_LOCK;
      HOLD:      o = OUT_HOLD;
      RUN:       o = OUT_RUN;
      SW_RST:    o = OUT_SW_RST;
      default:   o = OUT_WAIT_LOCK;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/reset_sequencer_sync_chain.sv
// sync_chain: STAGES-deep flop chain that brings a signal into the clk domain.
// The chain is asynchronously forced to RESET_VAL by async_reset.
//   clk         in  sampling clock
//   async_reset in  asynchronous active-high reset
//   d           in  signal to synchronize
//   q           out last stage of the chain
module sync_chain #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic async_reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      chain_q <= {STAGES{RESET_VAL}};
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d};
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: generates async, async-low and sync resets for the flop banks.
// Resets release only after the reset synchronizer has drained, the PLL lock is
// seen, and HOLD_CYCLES further cycles have passed. A software request in RUN
// produces a SW_PULSE_CYCLES-wide sync reset without touching the async reset.
//   clk             in  sole clock
//   async_reset     in  asynchronous active-high reset
//   i_pll_locked    in  PLL lock status, asynchronous to clk
//   i_sw_reset      in  software reset request, level sampled in RUN
//   o_async_reset   out active-high reset for async-reset flops
//   o_async_reset_n out exact complement of o_async_reset
//   o_sync_reset    out active-high reset for sync-reset flops
//   o_rst_done      out high only in RUN
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned HOLD_CYCLES     = 16,
  parameter int unsigned SW_PULSE_CYCLES = 4
) (
  input  logic clk,
  input  logic async_reset,
  input  logic i_pll_locked,
  input  logic i_sw_reset,
  output logic o_async_reset,
  output logic o_async_reset_n,
  output logic o_sync_reset,
  output logic o_rst_done
);

  localparam int unsigned MaxCnt = (HOLD_CYCLES > SW_PULSE_CYCLES) ? HOLD_CYCLES
                                                                    : SW_PULSE_CYCLES;
  localparam int unsigned CntW   = (MaxCnt > 1) ? $clog2(MaxCnt) : 1;
  localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] PulseLast = CntW'(SW_PULSE_CYCLES - 1);

  logic rst_s;
  logic locked_s;

  sync_chain #(
    .STAGES   (SYNC_STAGES),
    .RESET_VAL(1'b1)
  ) u_rst_sync (
    .clk        (clk),
    .async_reset(async_reset),
    .d          (1'b0),
    .q          (rst_s)
  );

  sync_chain #(
    .STAGES   (SYNC_STAGES),
    .RESET_VAL(1'b0)
  ) u_lock_sync (
    .clk        (clk),
    .async_reset(async_reset),
    .d          (i_pll_locked),
    .q          (locked_s)
  );

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  rst_out_t        out_q, out_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (rst_s) begin
      state_d = WAIT_LOCK;
      cnt_d   = '0;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          cnt_d = '0;
          if (locked_s) state_d = HOLD;
        end
        HOLD: begin
          if (!locked_s) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == HoldLast) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RUN: begin
          cnt_d = '0;
          if (!locked_s) begin
            state_d = WAIT_LOCK;
          end else if (i_sw_reset) begin
            state_d = SW_RST;
          end
        end
        SW_RST: begin
          // Requests here are ignored so the pulse width is fixed.
          if (!locked_s) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == PulseLast) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they move on the same edge.
  always_comb begin
    out_d = decode_outputs(state_d);
  end

  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      out_q   <= OUT_WAIT_LOCK;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  assign o_async_reset   = out_q.async_reset;
  assign o_async_reset_n = ~out_q.async_reset;
  assign o_sync_reset    = out_q.sync_reset;
  assign o_rst_done      = out_q.rst_done;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer (default parameters).
// Stimulus pushes the hand-computed output vector expected after the coming
// edge; a monitor pops it 1 ns after each rising edge and compares.
// Vector order: {o_async_reset, o_async_reset_n, o_sync_reset, o_rst_done}.
module tb_reset_sequencer;

  logic clk;
  logic async_reset;
  logic i_pll_locked;
  logic i_sw_reset;
  logic o_async_reset;
  logic o_async_reset_n;
  logic o_sync_reset;
  logic o_rst_done;

  localparam logic [3:0] RstV = 4'b1010;
  localparam logic [3:0] RunV = 4'b0101;
  localparam logic [3:0] SwV  = 4'b0110;

  typedef struct {
    logic [3:0] outs;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  reset_sequencer dut (
    .clk            (clk),
    .async_reset    (async_reset),
    .i_pll_locked   (i_pll_locked),
    .i_sw_reset     (i_sw_reset),
    .o_async_reset  (o_async_reset),
    .o_async_reset_n(o_async_reset_n),
    .o_sync_reset   (o_sync_reset),
    .o_rst_done     (o_rst_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] outs_now();
    return {o_async_reset, o_async_reset_n, o_sync_reset, o_rst_done};
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Expect `outs` after the next rising edge, then return at the falling edge.
  task automatic tick(input logic [3:0] outs, input string name);
    exp_t e;
    e.outs = outs;
    e.name = name;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  always begin
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check(mon_e.name, outs_now(), mon_e.outs);
    end
  end

  // Assert async_reset between edges, confirm the immediate effect, hold two
  // edges, release at a falling edge (edge 1 is the next rising edge).
  task automatic do_reset(input string name);
    #2;
    async_reset = 1'b1;
    #1;
    check({name, "_immediate"}, outs_now(), RstV);
    @(negedge clk);
    tick(RstV, {name, "_held0"});
    tick(RstV, {name, "_held1"});
    async_reset = 1'b0;
  endtask

  initial begin
    async_reset  = 1'b1;
    i_pll_locked = 1'b1;
    i_sw_reset   = 1'b0;

    // Power-on: reset held 5 cycles, then RUN at edge 19.
    for (int i = 0; i < 5; i++) tick(RstV, $sformatf("por_hold%0d", i));
    async_reset = 1'b0;
    for (int k = 1; k <= 22; k++)
      tick((k >= 19) ? RunV : RstV, $sformatf("por_edge%0d", k));

    // Late lock: lock sampled high first at edge 10, RUN at edge 28.
    i_pll_locked = 1'b0;
    do_reset("late");
    for (int k = 1; k <= 30; k++) begin
      if (k == 10) i_pll_locked = 1'b1;
      tick((k >= 28) ? RunV : RstV, $sformatf("late_edge%0d", k));
    end

    // Software reset: one-cycle request gives a 4-cycle sync pulse.
    i_sw_reset = 1'b1;
    for (int j = 0; j < 7; j++) begin
      tick((j < 4) ? SwV : RunV, $sformatf("sw_n+%0d", j));
      i_sw_reset = 1'b0;
    end

    // Second request mid-pulse does not extend it.
    for (int j = 0; j < 7; j++) begin
      i_sw_reset = (j == 0 || j == 2) ? 1'b1 : 1'b0;
      tick((j < 4) ? SwV : RunV, $sformatf("sw2_n+%0d", j));
    end
    i_sw_reset = 1'b0;

    // Lock loss at edge n, resets at n+2; relock at n+5, RUN at n+23.
    for (int j = 0; j <= 25; j++) begin
      if (j == 0) i_pll_locked = 1'b0;
      if (j == 5) i_pll_locked = 1'b1;
      tick((j < 2 || j >= 23) ? RunV : RstV, $sformatf("loss_n+%0d", j));
    end

    // Lock glitch in HOLD (low at edges 6..8): count restarts, RUN at 27.
    do_reset("glitch");
    for (int k = 1; k <= 30; k++) begin
      if (k == 6) i_pll_locked = 1'b0;
      if (k == 9) i_pll_locked = 1'b1;
      tick((k >= 27) ? RunV : RstV, $sformatf("glitch_edge%0d", k));
    end

    // Async reset during SW_RST, then the full sequence again.
    i_sw_reset = 1'b1;
    tick(SwV, "midsw_n");
    i_sw_reset = 1'b0;
    tick(SwV, "midsw_n+1");
    do_reset("midsw");
    for (int k = 1; k <= 22; k++)
      tick((k >= 19) ? RunV : RstV, $sformatf("midsw_edge%0d", k));

    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
